tristate_bus_arbiter: RTL and testbench



---
 rtl/tristate_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner select for N tri-state drivers on one shared line,
// with a fixed turnaround gap and a bounded hold time per grant.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   en,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [TW-1:0]  turn_q, turn_d;
  logic [N-1:0]   en_q, en_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           busy_q, busy_d;
  logic           preempt_q, preempt_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] next_ptr;
  logic           arb;

  // Rotate req so bit 0 is the current highest-priority requester.
  always_comb begin
    req_dbl   = {req, req} >> ptr_q;
    req_rot   = req_dbl[N-1:0];
    win_found = 1'b0;
    win_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(ptr_q) + i) % N);
      end
    end
  end

  assign next_ptr = (grant_id_q == IDW'(N - 1)) ?
                    '0 : grant_id_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    en_d       = en_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;
    arb        = 1'b0;
    unique case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (!req[grant_id_q] ||
            hold_q == HW'(MAX_HOLD)) begin
          preempt_d = req[grant_id_q];
          en_d      = '0;
          busy_d    = 1'b0;
          ptr_d     = next_ptr;
          turn_d    = TW'(1);
          state_d   = TURN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYC)) begin
          arb = 1'b1;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (win_found) begin
        en_d       = N'(1) << win_id;
        grant_id_d = win_id;
        busy_d     = 1'b1;
        hold_d     = HW'(1);
        state_d    = GRANT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_q     <= '0;
      turn_q     <= '0;
      en_q       <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      en_q       <= en_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign en       = en_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, MAX_HOLD=8, TURN_CYC=1).
// Scenario tasks check outputs 1ns after each rising edge.
module tb_tristate_bus_arbiter;

  localparam int N = 4;
  localparam int TURN_CYC = 1;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] en;
  logic [1:0] grant_id;
  logic       busy;
  logic       preempt;

  int vecs = 0;
  int errs = 0;

  tristate_bus_arbiter #(
    .N(4), .IDW(2), .MAX_HOLD(8), .TURN_CYC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .en(en),
    .grant_id(grant_id),
    .busy(busy),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle-level invariants, sampled on the falling edge.
  logic [3:0] prev_en = '0;
  int zero_run = 100;
  always @(negedge clk) begin
    vecs++;
    if (!$onehot0(en) || busy !== (|en)) begin
      errs++;
      $display("FAIL inv_onehot_busy en=%b busy=%b", en, busy);
    end
    if (en != 0 && prev_en != 0 && en != prev_en) begin
      errs++;
      $display("FAIL inv_gap en %b -> %b with no gap", prev_en, en);
    end
    if (en != 0 && prev_en == 0 && zero_run < TURN_CYC) begin
      errs++;
      $display("FAIL inv_gap zero_run=%0d need>=%0d", zero_run, TURN_CYC);
    end
    zero_run = (en == 0) ? zero_run + 1 : 0;
    prev_en = en;
  end

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 4'b0000;
    tick();
    tick();
    vecs++;
    if (en !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
      errs++;
      $display("FAIL reset en=%b busy=%b gid=%0d pre=%b want 0000/0/0/0",
               en, busy, grant_id, preempt);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (en !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
        errs++;
        $display("FAIL idle[%0d] en=%b busy=%b gid=%0d pre=%b", i, en, busy, grant_id, preempt);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (en !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1 || preempt !== 1'b0) begin
        errs++;
        $display("FAIL single[%0d] en=%b gid=%0d busy=%b want 0100/2/1", i, en, grant_id, busy);
      end
    end
    req = 4'b0000;
    tick();
    vecs++;
    if (en !== 4'b0 || busy !== 1'b0 || preempt !== 1'b0 || grant_id !== 2'd2) begin
      errs++;
      $display("FAIL single_release en=%b busy=%b pre=%b gid=%0d want 0000/0/0/2",
               en, busy, preempt, grant_id);
    end
    tick();
    vecs++;
    if (en !== 4'b0 || grant_id !== 2'd2 || preempt !== 1'b0) begin
      errs++;
      $display("FAIL single_idle en=%b gid=%0d pre=%b want 0000/2/0", en, grant_id, preempt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_en;
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_en = 4'b0001 << (i % 4);
      for (int c = 0; c < 2; c++) begin
        tick();
        vecs++;
        if (en !== exp_en || grant_id !== 2'(i % 4)) begin
          errs++;
          $display("FAIL rr[%0d.%0d] en=%b gid=%0d want %b/%0d", i, c, en, grant_id, exp_en, i % 4);
        end
      end
      req = 4'hF & ~exp_en;
      tick();
      vecs++;
      if (en !== 4'b0 || busy !== 1'b0 || preempt !== 1'b0) begin
        errs++;
        $display("FAIL rr_gap[%0d] en=%b busy=%b pre=%b want 0000/0/0", i, en, busy, preempt);
      end
      req = 4'hF;
    end
    req = 4'h0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        vecs++;
        if (en !== (4'b0001 << (r % 2)) || preempt !== 1'b0) begin
          errs++;
          $display("FAIL hold[%0d.%0d] en=%b pre=%b want %b/0", r, i, en, preempt, 4'b0001 << (r % 2));
        end
      end
      tick();
      vecs++;
      if (en !== 4'b0 || preempt !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL timeout[%0d] en=%b pre=%b busy=%b want 0000/1/0", r, en, preempt, busy);
      end
    end
    tick();
    vecs++;
    if (en !== 4'b0010 || preempt !== 1'b0) begin
      errs++;
      $display("FAIL timeout_alt en=%b pre=%b want 0010/0", en, preempt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    tick();
    vecs++;
    if (en !== 4'b1000 || grant_id !== 2'd3) begin
      errs++;
      $display("FAIL mid_pre en=%b gid=%0d want 1000/3", en, grant_id);
    end
    reset = 1'b0;
    tick();
    vecs++;
    if (en !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset en=%b busy=%b gid=%0d want 0000/0/0", en, busy, grant_id);
    end
    reset = 1'b1;
    req = 4'b1001;
    tick();
    vecs++;
    if (en !== 4'b0001 || grant_id !== 2'd0) begin
      errs++;
      $display("FAIL mid_regrant en=%b gid=%0d want 0001/0", en, grant_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    tick();
    vecs++;
    if (en !== 4'b1000 || grant_id !== 2'd3) begin
      errs++;
      $display("FAIL wrap_grant en=%b gid=%0d want 1000/3", en, grant_id);
    end
    req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (en !== 4'b1000) begin
        errs++;
        $display("FAIL wrap_late[%0d] en=%b want 1000", i, en);
      end
    end
    req = 4'b0010;
    tick();
    vecs++;
    if (en !== 4'b0 || preempt !== 1'b0) begin
      errs++;
      $display("FAIL wrap_turn en=%b pre=%b want 0000/0", en, preempt);
    end
    tick();
    vecs++;
    if (en !== 4'b0010 || grant_id !== 2'd1) begin
      errs++;
      $display("FAIL wrap_next en=%b gid=%0d want 0010/1", en, grant_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_wrap();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
